// File: rtl/data_addr_gen.sv
// Convolution window address generator: sweeps kernel offsets (kx, ky) inside
// each window base (bx, by) for one square feature-map pass.
//
// state    | meaning
// IDLE     | waiting for start; illegal configs pulse err here
// WAIT_MEM | config latched, waiting for data RAM ready
// RUN      | issuing read addresses, held off by stall
// DONE     | single-cycle done pulse before returning to IDLE
module data_addr_gen #(
  parameter int RAM_NUM = 32,
  parameter int ADDR_DW = 5,
  parameter int ROWS    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [5:0]         IN_DIM,
  input  logic [3:0]         KERNEL_DIM,
  input  logic [1:0]         STRIDE,
  input  logic               mem_sig,
  input  logic               stall,
  output logic [7:0]         addr_r_x,
  output logic [3:0]         addr_r_y,
  output logic [ADDR_DW-1:0] ram_select_r_x,
  output logic [ADDR_DW-1:0] ram_select_r_y,
  output logic               data_out_valid,
  output logic               tile_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [5:0]  in_dim_q;
  logic [3:0]  k_q;
  logic [1:0]  s_q;
  logic [7:0]  kx, bx, by;
  logic [3:0]  ky;
  logic        valid_q, last_q, done_q, err_q, busy_q;

  logic        cfg_illegal, accept;
  logic [3:0]  k_m1;
  logic [7:0]  lim, step_x;
  logic        kx_end, ky_end, win_end, bx_end, by_end, pass_end;
  logic        advance, valid_nx;
  logic [7:0]  kx_n, bx_n, by_n;
  logic [3:0]  ky_n;
  logic [7:0]  kx_sel;
  logic [3:0]  ky_sel;

  assign cfg_illegal = (KERNEL_DIM == 4'd0) || (STRIDE == 2'd0) ||
                       ({2'b00, KERNEL_DIM} > IN_DIM) ||
                       (32'(IN_DIM) > RAM_NUM);
  assign accept      = (state == IDLE) && start && !cfg_illegal;

  // Bounds are computed at 8 bits so base + step never wraps before the compare.
  assign k_m1     = k_q - 4'd1;
  assign lim      = {2'b00, in_dim_q} - {4'b0000, k_q};
  assign step_x   = 8'(s_q) * 8'(ROWS);
  assign kx_end   = (kx == {4'b0000, k_m1});
  assign ky_end   = (ky == k_m1);
  assign win_end  = kx_end && ky_end;
  assign bx_end   = (bx + step_x) > lim;
  assign by_end   = (by + {6'b000000, s_q}) > lim;
  assign pass_end = win_end && bx_end && by_end;

  // Counters move on the edge that closes a valid cycle.
  assign advance  = (state == RUN) && valid_q && !pass_end;
  assign valid_nx = (state_nx == RUN) && !stall;

  always_comb begin
    kx_n = kx;
    ky_n = ky;
    bx_n = bx;
    by_n = by;
    if (!kx_end) begin
      kx_n = kx + 8'd1;
    end else begin
      kx_n = 8'd0;
      if (!ky_end) begin
        ky_n = ky + 4'd1;
      end else begin
        ky_n = 4'd0;
        if (!bx_end) begin
          bx_n = bx + step_x;
        end else begin
          bx_n = 8'd0;
          by_n = by + {6'b000000, s_q};
        end
      end
    end
  end

  assign kx_sel = advance ? kx_n : kx;
  assign ky_sel = advance ? ky_n : ky;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = WAIT_MEM;
      WAIT_MEM: if (mem_sig) state_nx = RUN;
      RUN:      if (valid_q && pass_end) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_dim_q <= '0;
      k_q      <= '0;
      s_q      <= '0;
      kx       <= '0;
      ky       <= '0;
      bx       <= '0;
      by       <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      err_q   <= (state == IDLE) && start && cfg_illegal;
      done_q  <= (state_nx == DONE);
      busy_q  <= (state_nx == WAIT_MEM) || (state_nx == RUN);
      valid_q <= valid_nx;
      last_q  <= valid_nx && (kx_sel == {4'b0000, k_m1}) && (ky_sel == k_m1);
      if (accept) begin
        in_dim_q <= IN_DIM;
        k_q      <= KERNEL_DIM;
        s_q      <= STRIDE;
        kx       <= '0;
        ky       <= '0;
        bx       <= '0;
        by       <= '0;
      end else if (advance) begin
        kx <= kx_n;
        ky <= ky_n;
        bx <= bx_n;
        by <= by_n;
      end
    end
  end

  assign addr_r_x       = kx;
  assign addr_r_y       = ky;
  assign ram_select_r_x = bx[ADDR_DW-1:0];
  assign ram_select_r_y = by[ADDR_DW-1:0];
  assign data_out_valid = valid_q;
  assign tile_last      = last_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_data_addr_gen.sv
// Self-checking bench for data_addr_gen: directed scenarios plus randomized
// passes compared against a nested-loop reference of the sweep order.
module tb_data_addr_gen;
  localparam int ROWS = 8;
  localparam int ADW  = 5;

  logic           clk = 1'b0;
  logic           rst_n, start, mem_sig, stall;
  logic [5:0]     IN_DIM;
  logic [3:0]     KERNEL_DIM;
  logic [1:0]     STRIDE;
  logic [7:0]     addr_r_x;
  logic [3:0]     addr_r_y;
  logic [ADW-1:0] ram_select_r_x, ram_select_r_y;
  logic           data_out_valid, tile_last, busy, done, err;

  int n_checks = 0;
  int n_err    = 0;

  data_addr_gen #(.RAM_NUM(32), .ADDR_DW(ADW), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .IN_DIM(IN_DIM),
    .KERNEL_DIM(KERNEL_DIM), .STRIDE(STRIDE), .mem_sig(mem_sig),
    .stall(stall), .addr_r_x(addr_r_x), .addr_r_y(addr_r_y),
    .ram_select_r_x(ram_select_r_x), .ram_select_r_y(ram_select_r_y),
    .data_out_valid(data_out_valid), .tile_last(tile_last), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int kx, input int ky, input int bx,
                                     input int by, input bit tl);
    return {8'(kx), 4'(ky), 8'(bx), 8'(by), 3'b000, tl};
  endfunction

  function automatic logic [31:0] obs_addr();
    return {addr_r_x, addr_r_y, 3'b000, ram_select_r_x, 3'b000, ram_select_r_y,
            3'b000, tile_last};
  endfunction

  function automatic logic [31:0] obs_all();
    return {addr_r_x, addr_r_y, 3'b000, ram_select_r_x, 3'b000, ram_select_r_y,
            data_out_valid, tile_last, busy, done};
  endfunction

  // stall_mode: 0 none, 1 random, 2 three cycles after the 4th valid.
  task automatic run_pass(input int in_d, input int k, input int s, input int stall_mode,
                          input int memlow, input int restart_at, input int reset_at);
    logic [31:0] q[$];
    int lim, wx, exp_nv, nv, nt, c_end, stall_left, budget;
    bit stall_prev, ended, stalled_once, restarted;
    lim = in_d - k;
    for (int y = 0; y <= lim; y += s)
      for (int x = 0; x <= lim; x += s * ROWS)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++)
            q.push_back(pk(kx, ky, x, y, (kx == k - 1) && (ky == k - 1)));
    wx     = lim / s + 1;
    exp_nv = ((wx + ROWS - 1) / ROWS) * wx * k * k;
    budget = 3 * exp_nv + 50;

    mem_sig = (memlow == 0); stall = 1'b0;
    IN_DIM = 6'(in_d); KERNEL_DIM = 4'(k); STRIDE = 2'(s); start = 1'b1;
    tick();
    start = 1'b0;
    check("wait_busy_valid", {busy, data_out_valid}, 2'b10);
    for (int i = 0; i < memlow; i++) begin
      tick();
      check("memlow_busy_valid", {busy, data_out_valid, done}, 3'b100);
    end
    mem_sig = 1'b1;

    nv = 0; nt = 0; c_end = -1; stall_left = 0;
    stall_prev = 1'b0; ended = 1'b0; stalled_once = 1'b0; restarted = 1'b0;
    for (int c = 0; c < budget && !ended; c++) begin
      tick();
      if (q.size() == 0) begin
        check("done_pulse", {done, busy, data_out_valid, tile_last}, 4'b1000);
        ended = 1'b1;
        c_end = c;
      end else begin
        check("run_valid", {data_out_valid, done, busy}, {!stall_prev, 1'b0, 1'b1});
        if (data_out_valid) begin
          nv++;
          if (tile_last) nt++;
          check("addr_tuple", obs_addr(), q.pop_front());
        end else begin
          check("stall_tile_last", {31'd0, tile_last}, 32'd0);
        end
      end
      if (!ended && reset_at >= 0 && nv == reset_at) begin
        rst_n = 1'b0;
        tick();
        check("midpass_reset_outputs", obs_all(), 32'd0);
        rst_n = 1'b1;
        stall = 1'b0;
        tick();
        check("after_reset_no_done", {obs_all(), err}, 33'd0);
        return;
      end
      if (!restarted && restart_at >= 0 && nv == restart_at) begin
        IN_DIM = 6'd5; KERNEL_DIM = 4'd1; STRIDE = 2'd1; start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (stall_mode == 2 && !stalled_once && nv == 4) begin
        stall_left = 3;
        stalled_once = 1'b1;
      end
      case (stall_mode)
        1: stall = ($urandom_range(0, 3) == 0);
        2: begin stall = (stall_left > 0); if (stall_left > 0) stall_left--; end
        default: stall = 1'b0;
      endcase
      stall_prev = stall;
    end
    stall = 1'b0; start = 1'b0;
    check("pass_finished_in_budget", {31'd0, ended}, 32'd1);
    check("valid_count", nv, exp_nv);
    check("tile_last_count", nt, exp_nv / (k * k));
    if (stall_mode != 1) check("done_latency", c_end, exp_nv + (stall_mode == 2 ? 3 : 0));
    tick();
    check("back_to_idle", {busy, done, data_out_valid}, 3'b000);
  endtask

  task automatic err_case(input int in_d, input int k, input int s);
    IN_DIM = 6'(in_d); KERNEL_DIM = 4'(k); STRIDE = 2'(s); start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", {err, busy, data_out_valid, done}, 4'b1000);
    tick();
    check("err_one_cycle", {err, busy, data_out_valid, done}, 4'b0000);
  endtask

  initial begin
    int in_d, k, s;
    rst_n = 1'b0; start = 1'b0; mem_sig = 1'b0; stall = 1'b0;
    IN_DIM = '0; KERNEL_DIM = '0; STRIDE = '0;
    tick(); tick();
    check("reset_state", {obs_all(), err}, 33'd0);
    rst_n = 1'b1;
    tick();

    run_pass(10, 3, 1, 0, 0, -1, -1);
    run_pass(32, 5, 2, 0, 0, -1, -1);
    run_pass(10, 3, 1, 2, 0, -1, -1);
    run_pass(10, 3, 1, 0, 10, 10, -1);
    err_case(10, 0, 1);
    err_case(5, 6, 1);
    err_case(10, 3, 0);
    run_pass(10, 3, 1, 0, 0, -1, 20);
    run_pass(10, 3, 1, 0, 0, -1, -1);
    run_pass(12, 2, 3, 1, 2, -1, -1);

    for (int p = 0; p < 6; p++) begin
      in_d = $urandom_range(1, 20);
      k    = $urandom_range(1, (in_d < 6) ? in_d : 6);
      s    = $urandom_range(1, 3);
      run_pass(in_d, k, s, 1, $urandom_range(0, 4), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
